// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-requester DMem arbiter.
// Optional build feature: ARB_PERF_EN (performance counters in dmem_arbiter).
package dmem_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int REQ_CORE   = 0;
    localparam int REQ_LOADER = 1;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_BURST = 4;
    localparam int PERF_W        = 32;

    // Burst counter needs at least one bit even when MAX_BURST is 1.
    function automatic int cnt_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake plus DMem port bundle for dmem_arbiter.
// master = environment (requesters + memory), slave = arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_we;
    logic [1:0]          req_lock;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          resp_valid;
    logic [DATA_W-1:0]   resp_rdata;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wd;
    logic [DATA_W-1:0]   mem_rd;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, mem_we, mem_addr, mem_wd
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, mem_we, mem_addr, mem_wd
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: on conflict the requester
// that was not served last wins.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester DMem arbiter: zero-latency grant, round-robin on conflict,
// bounded burst locking, registered read response. Optional: ARB_PERF_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                clk,
    input  logic                reset,
    dmem_arbiter_if.slave       bus
`ifdef ARB_PERF_EN
    ,
    output logic [PERF_W-1:0]   grant_cnt0,
    output logic [PERF_W-1:0]   grant_cnt1,
    output logic [PERF_W-1:0]   conflict_cnt
`endif
);

    localparam int CNT_W      = cnt_width(MAX_BURST);
    localparam int LAST_BURST = MAX_BURST - 1;

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

    logic [1:0]        rr_grant;
    logic [1:0]        grant;
    logic              gidx;
    logic              xfer;
    logic              rd_xfer;

    logic [1:0]        resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;

    rr_pick2 u_pick (
        .valid (bus.req_valid),
        .last  (last_q),
        .grant (rr_grant)
    );

    // While locked only the owner can be granted; the other side stalls.
    always_comb begin
        grant = '0;
        unique case (state_q)
            ARB_IDLE:   grant = rr_grant;
            ARB_LOCKED: grant[owner_q] = bus.req_valid[owner_q];
            default:    grant = '0;
        endcase
    end

    assign gidx    = grant[REQ_LOADER];
    assign xfer    = |grant;
    assign rd_xfer = xfer && !bus.req_we[gidx];

    always_comb begin
        bus.req_ready = grant;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wd    = '0;
        if (xfer) begin
            bus.mem_we   = bus.req_we[gidx];
            bus.mem_addr = gidx ? bus.req_addr[ADDR_W +: ADDR_W]
                                : bus.req_addr[0 +: ADDR_W];
            bus.mem_wd   = gidx ? bus.req_wdata[DATA_W +: DATA_W]
                                : bus.req_wdata[0 +: DATA_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        if (xfer) begin
            if (bus.req_lock[gidx] && (int'(burst_cnt_q) < LAST_BURST)) begin
                state_d     = ARB_LOCKED;
                owner_d     = gidx;
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end else begin
                state_d     = ARB_IDLE;
                last_d      = gidx;
                burst_cnt_d = '0;
            end
        end else if (state_q == ARB_LOCKED && !bus.req_lock[owner_q]) begin
            // Idle owner releasing the lock hands the bus back to round-robin.
            state_d     = ARB_IDLE;
            last_d      = owner_q;
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= rd_xfer ? grant : 2'b00;
            if (rd_xfer) begin
                resp_rdata_q <= bus.mem_rd;
            end
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;

`ifdef ARB_PERF_EN
    logic conflict;
    assign conflict = |(bus.req_valid & ~grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt0   <= '0;
            grant_cnt1   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant[REQ_CORE] && grant_cnt0 != '1) begin
                grant_cnt0 <= grant_cnt0 + PERF_W'(1);
            end
            if (grant[REQ_LOADER] && grant_cnt1 != '1) begin
                grant_cnt1 <= grant_cnt1 + PERF_W'(1);
            end
            if (conflict && conflict_cnt != '1) begin
                conflict_cnt <= conflict_cnt + PERF_W'(1);
            end
        end
    end
`endif

endmodule
